mem_responder: RTL
==================

Name: mem_responder

Overview:
- Synthesizable memory-side model that answers the accelerator's memory request interface (mem_req/mem_wr/mem_rd).
- Replaces the MemDPI stub in FPGA/standalone-sim builds.
- Holds a word-addressed RAM and serves one burst at a time: reads return beats under rd_ready backpressure; writes absorb beats.
- Includes a backdoor port so the bench can preload and inspect RAM.

Parameters:
- MEM_LEN_BITS, 8: width of mem_req_len; burst beats = len+1
- MEM_ADDR_BITS, 32: byte address width
- MEM_DATA_BITS, 64: beat width; power of two, >= 8
- DEPTH_BITS, 10: RAM holds 2**DEPTH_BITS words of MEM_DATA_BITS
- RD_LATENCY, 1: cycles from request acceptance to first mem_rd_valid; minimum 1

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; reset applied when 0 at a rising edge
- mem_req_valid  in  1  request strobe, one cycle per request
- mem_req_opcode  in  1  0 = read, 1 = write
- mem_req_len  in  MEM_LEN_BITS  beats minus one
- mem_req_addr  in  MEM_ADDR_BITS  byte address of first beat
- mem_wr_valid  in  1  write beat strobe; no backpressure
- mem_wr_bits  in  MEM_DATA_BITS  write beat data
- mem_rd_valid  out  1  read beat valid
- mem_rd_bits  out  MEM_DATA_BITS  read beat data
- mem_rd_ready  in  1  initiator accepts read beat
- bd_we  in  1  backdoor write enable
- bd_addr  in  DEPTH_BITS  backdoor word index
- bd_wdata  in  MEM_DATA_BITS  backdoor write data
- bd_rdata  out  MEM_DATA_BITS  backdoor read data, 1-cycle registered
- busy  out  1  high when not IDLE
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset==0 at edge): state=IDLE; mem_rd_valid=0, mem_rd_bits=0, bd_rdata=0, busy=0, err=0, beat counter=0. RAM contents are not cleared. Reset mid-burst aborts the burst immediately; remaining beats are discarded.
- Word index = (mem_req_addr >> log2(MEM_DATA_BITS/8)) mod 2**DEPTH_BITS. Low byte-offset bits are ignored. The index increments by 1 per beat and wraps from 2**DEPTH_BITS-1 to 0.
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA.
- IDLE: on mem_req_valid, latch index and remaining count = len+1 (MEM_LEN_BITS+1 bits, so len=255 gives 256 beats).
  - opcode=0 -> RD_WAIT.
  - opcode=1 -> WR_DATA.
- RD_WAIT: count RD_LATENCY-1 cycles, issuing the RAM read. mem_rd_valid rises exactly RD_LATENCY cycles after the acceptance edge. With RD_LATENCY=1, the first beat is valid the cycle after acceptance.
- RD_DATA: mem_rd_valid=1, mem_rd_bits=RAM[index].
  - Beat transfers on valid&&ready.
  - While ready=0, valid and bits stay stable.
  - On transfer: index++, count--, next word presented the following cycle with no bubble (prefetch). Sustained throughput is 1 beat/cycle while ready=1.
  - After the last transfer: mem_rd_valid=0 next cycle, state=IDLE.
- WR_DATA: each mem_wr_valid cycle writes mem_wr_bits to RAM[index], then index++, count--. After the last beat, state=IDLE on the next edge. Write beats may be non-contiguous in time.
- Request accepted only in IDLE. A request in the same cycle as the final beat is not accepted.
- Errors (err set, held until reset):
  - mem_req_valid while not IDLE: request dropped.
  - mem_wr_valid outside WR_DATA: beat dropped, RAM unchanged.
- Backdoor:
  - bd_we writes RAM[bd_addr] in any state.
  - bd_rdata = RAM[bd_addr] from the previous edge, i.e. old data on same-address write (read-before-write).
  - If a protocol write and bd_we target the same word in the same cycle, the protocol write wins.
- Read of a word written in the same cycle returns old data. Prefetch happens after the write edge, so back-to-back write-then-read bursts see the new data.
- busy = (state != IDLE).

Test Plan:
- Preload via backdoor words 0..3 = 0x11,0x22,0x33,0x44. Read req addr=0x8, len=2, ready=1 -> rd_valid starts 1 cycle after accept; beats 0x22,0x33,0x44 on consecutive cycles; busy falls after the 3rd beat; err=0.
- Same read with ready toggled 1,0,0,1,1 -> each beat held stable while ready=0; exactly 3 transfers, in order, with no duplicates.
- Write req addr=0x10, len=1, wr beats 0xA5 (gap of 2 idle cycles) 0x5A -> backdoor read of words 2,3 returns 0xA5,0x5A; state returns to IDLE.
- Wrap: DEPTH_BITS=10, read at word 1023, len=1 -> beats RAM[1023], RAM[0].
- Errors: second mem_req_valid during a read burst, and mem_wr_valid in IDLE -> err=1 and stays set; the current burst completes correctly; RAM unchanged.
- Reset (reset=0) mid-read on beat 2 of 4 -> next cycle rd_valid=0, busy=0, err=0; a new read afterwards returns correct data.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: synthesizable memory-side responder for the accelerator
// memory request interface. It holds a word-addressed RAM, serves one burst
// at a time (reads under rd_ready backpressure, writes without backpressure)
// and exposes a backdoor port for preload and inspection.

module mem_responder #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_BITS    = 10,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     mem_req_valid,
  input  logic                     mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,

  input  logic                     mem_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,

  output logic                     mem_rd_valid,
  output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  input  logic                     mem_rd_ready,

  input  logic                     bd_we,
  input  logic [DEPTH_BITS-1:0]    bd_addr,
  input  logic [MEM_DATA_BITS-1:0] bd_wdata,
  output logic [MEM_DATA_BITS-1:0] bd_rdata,

  output logic                     busy,
  output logic                     err
);

  // Byte-offset bits dropped from the request address to form a word index.
  localparam int OFFSET_BITS = $clog2(MEM_DATA_BITS / 8);
  // Remaining-beat counter is one bit wider than len so len=max fits len+1.
  localparam int CNT_BITS    = MEM_LEN_BITS + 1;
  localparam int WORDS       = 1 << DEPTH_BITS;
  // RD_WAIT lasts RD_LATENCY-1 cycles; the counter runs down to zero.
  localparam int WAIT_BITS   = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WAIT_BITS-1:0] WAIT_INIT =
    WAIT_BITS'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  // FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_DATA = 2'd2;
  localparam logic [1:0] ST_WR_DATA = 2'd3;

  logic [MEM_DATA_BITS-1:0] mem [WORDS];

  logic [1:0]               state;
  logic [DEPTH_BITS-1:0]    index;
  logic [CNT_BITS-1:0]      count;
  logic [WAIT_BITS-1:0]     wait_cnt;

  logic [DEPTH_BITS-1:0]    req_index;
  logic [DEPTH_BITS-1:0]    next_index;
  logic [DEPTH_BITS-1:0]    rd_addr;
  logic                     rd_xfer;
  logic                     wr_fire;
  logic                     last_beat;
  logic                     proto_err;
  logic                     unused_addr_bits;

  // Word index of the first beat; bits outside the RAM window are ignored.
  assign req_index        = mem_req_addr[OFFSET_BITS +: DEPTH_BITS];
  assign unused_addr_bits = ^mem_req_addr;

  assign next_index = index + DEPTH_BITS'(1);
  assign last_beat  = (count == CNT_BITS'(1));
  assign rd_xfer    = (state == ST_RD_DATA) && mem_rd_valid && mem_rd_ready;
  assign wr_fire    = (state == ST_WR_DATA) && mem_wr_valid;
  assign proto_err  = (mem_req_valid && (state != ST_IDLE)) ||
                      (mem_wr_valid  && (state != ST_WR_DATA));
  assign busy       = (state != ST_IDLE);

  // Select which word the read side loads into mem_rd_bits this cycle:
  // the request's first word on acceptance, the current word after the wait,
  // or the following word when a beat transfers (prefetch, no bubble).
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    rd_addr = index;
    case (state)
      ST_IDLE:    rd_addr = req_index;
      ST_RD_DATA: rd_addr = next_index;
      default:    rd_addr = index;
    endcase
  end

  // Burst control FSM, read-beat register and sticky error flag.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, regardless of statement order.
    if (!reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_bits  <= '0;
      err          <= 1'b0;
    end else begin
      if (proto_err) begin
        err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (mem_req_valid) begin
            index <= req_index;
            count <= CNT_BITS'(mem_req_len) + CNT_BITS'(1);
            if (mem_req_opcode) begin
              state <= ST_WR_DATA;
            end else if (RD_LATENCY == 1) begin
              // First beat is presented the cycle after acceptance.
              state        <= ST_RD_DATA;
              mem_rd_valid <= 1'b1;
              mem_rd_bits  <= mem[rd_addr];
            end else begin
              state    <= ST_RD_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            state        <= ST_RD_DATA;
            mem_rd_valid <= 1'b1;
            mem_rd_bits  <= mem[rd_addr];
          end else begin
            wait_cnt <= wait_cnt - WAIT_BITS'(1);
          end
        end

        ST_RD_DATA: begin
          // Without a transfer, valid and bits simply hold.
          if (rd_xfer) begin
            index <= next_index;
            count <= count - CNT_BITS'(1);
            if (last_beat) begin
              state        <= ST_IDLE;
              mem_rd_valid <= 1'b0;
            end else begin
              mem_rd_bits <= mem[rd_addr];
            end
          end
        end

        ST_WR_DATA: begin
          if (mem_wr_valid) begin
            index <= next_index;
            count <= count - CNT_BITS'(1);
            if (last_beat) begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM write port: backdoor first, protocol write last so it wins a
  // same-word collision. Backdoor writes are honoured in any state.
  always_ff @(posedge clock) begin
    // NOTE: the RAM array has no reset; its contents survive reset and only
    // the control registers around it are cleared.
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (reset && wr_fire) begin
      mem[index] <= mem_wr_bits;
    end
  end

  // Backdoor read: registered, returns the word as it was before this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bd_rdata <= '0;
    end else begin
      bd_rdata <= mem[bd_addr];
    end
  end

endmodule
